bsg_asic_out_channel_tx: RTL and testbench
==========================================

Name: bsg_asic_out_channel_tx

Overview:
- Per-channel transmit stage that sits directly upstream of the ASIC output delay block.
- Takes 16-bit words from a core-side valid/ready source and sends each word as two bytes, low byte first.
- Drives an 8-bit data lane, a valid bit and a forwarded clock toggling at half the core clock. Four instances feed the clk/valid/data_{a..d} inputs of the delay block.
- Enforces credit-based flow control from far-side token returns and can emit a fixed training pattern for delay calibration.

Parameters:
- credits_p, 16: initial and maximum credit count, in words; legal range 1..255.
- credit_width_lp, $clog2(credits_p+1): width of the credit counter (derived; not overridden).

Ports:
- clk_i  input  1  core clock; all state on rising edge
- reset_n_i  input  1  reset, asynchronous, active-low
- data_i  input  16  word to send; [7:0] sent first
- v_i  input  1  data_i valid
- ready_o  output  1  word accepted on a cycle where v_i & ready_o
- calib_en_i  input  1  request training-pattern mode
- token_i  input  1  one-cycle pulse, returns one credit; already synchronous to clk_i
- clk_o  output  1  forwarded clock, to the delay block clk input
- data_o  output  8  byte lane, to the delay block data input
- valid_o  output  1  byte valid, to the delay block valid input
- credits_o  output  credit_width_lp  current credit count
- calib_o  output  1  pattern mode active
- overflow_o  output  1  sticky: token received with credits already at credits_p

Behaviour:
- Reset values (asynchronous assertion):
  - ph=0, clk_o=0, data_o=0, valid_o=0.
  - credits_o=credits_p, calib_o=0, overflow_o=0.
  - FSM in IDLE; any in-flight word is dropped.
- Reset release takes effect at the first clk_i edge after reset_n_i rises.
- Phase and forwarded clock:
  - ph toggles every cycle out of reset; clk_o is ph registered.
  - clk_o period = 2 clk_i cycles, 50% duty.
  - Byte changes align to clk_o edges; the delay block centres them.
- Slots: a slot is two cycles, beginning in the cycle after ph==1. Mode changes and word acceptance happen only at slot boundaries (cycles with ph==1).
- ready_o = (ph==1) & (state!=CALIB) & ~calib_en_i & (credits_o!=0).
- FSM states:
  - IDLE: valid_o=0, data_o=0.
    - Goes to LO at a boundary with v_i & ready_o; data_i is latched into the word register.
    - Goes to CALIB at a boundary with calib_en_i=1.
  - LO: data_o=word[7:0], valid_o=1; always goes to HI.
  - HI: data_o=word[15:8], valid_o=1. At the next boundary:
    - goes to LO if another word is accepted (back-to-back transfer with no bubble);
    - otherwise goes to CALIB if calib_en_i=1, else IDLE.
  - CALIB: calib_o=1. Each slot drives data_o=8'hAA with valid_o=1, then data_o=8'h55 with valid_o=0. At a boundary with calib_en_i=0, goes to IDLE.
- Priority: calib_en_i beats v_i at a boundary. A word in HI always completes before CALIB is entered.
- Latency: a word accepted at the edge ending cycle t gives its low byte in cycle t+1 and its high byte in cycle t+2.
- Credits:
  - Decrement on acceptance; increment on token_i; no change if both happen in the same cycle.
  - If token_i arrives with credits_o==credits_p and no acceptance that cycle, the count saturates and overflow_o sets. overflow_o clears only on reset.
  - Credit 0 blocks acceptance only. In-flight bytes and CALIB are unaffected.
  - CALIB consumes no credits.
- Throughput: maximum one word per 2 cycles.

Test Plan:
- Reset and idle: reset_n_i low for 3 cycles, then release → clk_o toggles 0,1,0,1 from the first edge; data_o=0, valid_o=0, credits_o=16, ready_o high only on ph==1 cycles.
- Single word: data_i=16'hBEEF accepted at cycle t → data_o=8'hEF with valid_o=1 at t+1, 8'hBE with valid_o=1 at t+2, valid_o=0 at t+3; credits_o goes 16→15.
- Back-to-back and credit exhaustion: 16 words with v_i held high and no tokens → continuous valid_o for 32 cycles; credits_o=0; ready_o stays low until a token_i pulse, after which the next word goes out and credits_o returns to 0.
- Simultaneous token and accept with credits_o=5 → credits_o stays 5. Token with credits_o=16 and no accept → credits_o stays 16, overflow_o=1 and stays high.
- Calibration: calib_en_i raised while a word is in HI → word completes, then repeating pattern AA/valid_o=1, 55/valid_o=0 with calib_o=1 and ready_o=0. Dropping calib_en_i → IDLE at the next boundary.
- Mid-word reset: assert reset_n_i during LO → outputs clear immediately without waiting for a clock; credits_o=16, overflow_o=0; no HI byte appears after release.

Source files
------------

// File: rtl/bsg_asic_out_channel_tx.sv
// Per-channel transmit stage feeding the ASIC output delay block.
// Serialises 16-bit words into byte pairs, forwards a half-rate clock and tracks credits.
module bsg_asic_out_channel_tx #(
    parameter  int credits_p       = 16,
    localparam int credit_width_lp = $clog2(credits_p+1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [15:0]                data_i,
    input  logic                       v_i,
    output logic                       ready_o,
    input  logic                       calib_en_i,
    input  logic                       token_i,
    output logic                       clk_o,
    output logic [7:0]                 data_o,
    output logic                       valid_o,
    output logic [credit_width_lp-1:0] credits_o,
    output logic                       calib_o,
    output logic                       overflow_o
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        CALIB
    } state_e;

    localparam logic [credit_width_lp-1:0] credits_max_lp =
        credit_width_lp'(credits_p);

    state_e                     state_r;
    state_e                     state_n;
    logic                       ph_r;
    logic [15:0]                word_r;
    logic [15:0]                word_n;
    logic [7:0]                 data_n;
    logic                       valid_n;
    logic [credit_width_lp-1:0] credits_n;
    logic                       overflow_n;
    logic                       accept;

    assign ready_o = ph_r
                   & (state_r != CALIB)
                   & ~calib_en_i
                   & (credits_o != '0);

    assign accept  = v_i & ready_o;
    assign calib_o = (state_r == CALIB);

    // Slot boundaries are the ph==1 cycles; LO always lands on ph==0.
    always_comb begin
        state_n = state_r;
        word_n  = word_r;
        unique case (state_r)
            IDLE: begin
                if (ph_r) begin
                    if (calib_en_i) state_n = CALIB;
                    else if (accept) state_n = LO;
                end
            end
            LO: state_n = HI;
            HI: begin
                if (ph_r) begin
                    if (accept) state_n = LO;
                    else if (calib_en_i) state_n = CALIB;
                    else state_n = IDLE;
                end
            end
            CALIB: begin
                if (ph_r && !calib_en_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (accept) word_n = data_i;
    end

    // Byte lane is registered from the next state so it moves on clk_o edges.
    always_comb begin
        data_n  = 8'h00;
        valid_n = 1'b0;
        unique case (state_n)
            LO: begin
                data_n  = word_n[7:0];
                valid_n = 1'b1;
            end
            HI: begin
                data_n  = word_n[15:8];
                valid_n = 1'b1;
            end
            CALIB: begin
                data_n  = ph_r ? 8'hAA : 8'h55;
                valid_n = ph_r;
            end
            default: begin
                data_n  = 8'h00;
                valid_n = 1'b0;
            end
        endcase
    end

    always_comb begin
        credits_n  = credits_o;
        overflow_n = overflow_o;
        if (token_i && !accept) begin
            if (credits_o == credits_max_lp) overflow_n = 1'b1;
            else credits_n = credits_o + 1'b1;
        end else if (accept && !token_i) begin
            credits_n = credits_o - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ph_r       <= 1'b0;
            clk_o      <= 1'b0;
            state_r    <= IDLE;
            word_r     <= 16'h0000;
            data_o     <= 8'h00;
            valid_o    <= 1'b0;
            credits_o  <= credits_max_lp;
            overflow_o <= 1'b0;
        end else begin
            ph_r       <= ~ph_r;
            clk_o      <= ph_r;
            state_r    <= state_n;
            word_r     <= word_n;
            data_o     <= data_n;
            valid_o    <= valid_n;
            credits_o  <= credits_n;
            overflow_o <= overflow_n;
        end
    end

endmodule

// File: tb/tb_bsg_asic_out_channel_tx.sv
// Scoreboard bench for bsg_asic_out_channel_tx.
// Stimulus pushes expected bytes with their cycle; a negedge monitor pops and compares.
module tb_bsg_asic_out_channel_tx;

    localparam int S_IDLE  = 0;
    localparam int S_LO    = 1;
    localparam int S_HI    = 2;
    localparam int S_CALIB = 3;

    typedef struct {
        logic [7:0] b;
        int         c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] data_i = 16'h0000;
    logic        v_i = 1'b0;
    logic        calib_en = 1'b0;
    logic        token = 1'b0;
    logic        ready_o;
    logic        clk_o;
    logic [7:0]  data_o;
    logic        valid_o;
    logic [4:0]  credits_o;
    logic        calib_o;
    logic        overflow_o;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t q[$];

    int   m_st;
    int   m_cred;
    bit   m_ph;
    bit   m_clk;
    bit   m_ovf;
    bit   last_acc;

    bsg_asic_out_channel_tx #(.credits_p(16)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .data_i     (data_i),
        .v_i        (v_i),
        .ready_o    (ready_o),
        .calib_en_i (calib_en),
        .token_i    (token),
        .clk_o      (clk_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .credits_o  (credits_o),
        .calib_o    (calib_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_st   = S_IDLE;
        m_cred = 16;
        m_ph   = 1'b0;
        m_clk  = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // One cycle: check state-level outputs, book expectations, advance model.
    task automatic step();
        bit m_ready;
        bit acc;
        #1;
        m_ready = m_ph && (m_st != S_CALIB) && !calib_en && (m_cred != 0);
        chk("ready_o", ready_o, m_ready);
        chk("credits_o", credits_o, m_cred);
        chk("overflow_o", overflow_o, m_ovf);
        chk("calib_o", calib_o, m_st == S_CALIB);
        chk("clk_o", clk_o, m_clk);
        if (m_st == S_IDLE) begin
            chk("idle_valid", valid_o, 0);
            chk("idle_data", data_o, 0);
        end
        if (m_st == S_CALIB) begin
            chk("calib_valid", valid_o, !m_ph);
            chk("calib_data", data_o, m_ph ? 8'h55 : 8'hAA);
        end
        acc = m_ready && v_i;
        last_acc = acc;
        if (acc) begin
            q.push_back('{data_i[7:0], cyc + 1});
            q.push_back('{data_i[15:8], cyc + 2});
        end
        if (m_ph) begin
            case (m_st)
                S_IDLE:  m_st = calib_en ? S_CALIB : (acc ? S_LO : S_IDLE);
                S_HI:    m_st = acc ? S_LO : (calib_en ? S_CALIB : S_IDLE);
                S_CALIB: if (!calib_en) m_st = S_IDLE;
                default: ;
            endcase
        end else if (m_st == S_LO) begin
            m_st = S_HI;
        end
        if (acc && !token) m_cred--;
        else if (token && !acc) begin
            if (m_cred == 16) m_ovf = 1'b1;
            else m_cred++;
        end
        m_clk = m_ph;
        m_ph  = !m_ph;
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] w);
        bit done;
        done   = 1'b0;
        v_i    = 1'b1;
        data_i = w;
        for (int i = 0; i < 8 && !done; i++) begin
            step();
            done = last_acc;
        end
        v_i = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (reset_n && !calib_o) begin
            if (valid_o) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_byte: got %h, required no byte (cycle %0d)",
                             data_o, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("byte_data", data_o, e.b);
                    chk("byte_cycle", cyc, e.c);
                end
            end else if (q.size() != 0 && q[0].c <= cyc) begin
                chk("missing_byte", 0, q[0].b);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int count;
        bit done;
        model_reset();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_clk_o", clk_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_credits", credits_o, 16);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_calib", calib_o, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) step();

        send(16'hBEEF);
        repeat (4) step();
        chk("single_credits", credits_o, 15);

        token = 1'b1;
        step();
        token = 1'b0;
        step();
        chk("refill_credits", credits_o, 16);

        count  = 0;
        v_i    = 1'b1;
        data_i = 16'h3000;
        for (int i = 0; i < 60 && count < 16; i++) begin
            step();
            if (last_acc) begin
                count++;
                data_i = 16'h3000 + 16'(count) * 16'h0101;
            end
        end
        chk("b2b_count", count, 16);
        repeat (6) step();
        chk("exhaust_credits", credits_o, 0);
        chk("exhaust_ready", ready_o, 0);

        token = 1'b1;
        step();
        token = 1'b0;
        done  = 1'b0;
        for (int i = 0; i < 6 && !done; i++) begin
            step();
            done = last_acc;
        end
        chk("token_release", done, 1);
        v_i = 1'b0;
        repeat (4) step();
        chk("after_token_credits", credits_o, 0);

        token = 1'b1;
        repeat (5) step();
        token = 1'b0;
        step();
        chk("five_credits", credits_o, 5);
        if (!m_ph) step();
        v_i    = 1'b1;
        token  = 1'b1;
        data_i = 16'h5AA5;
        step();
        v_i   = 1'b0;
        token = 1'b0;
        repeat (3) step();
        chk("simul_credits", credits_o, 5);

        token = 1'b1;
        repeat (11) step();
        token = 1'b0;
        step();
        chk("full_credits", credits_o, 16);
        chk("full_overflow", overflow_o, 0);
        token = 1'b1;
        step();
        token = 1'b0;
        repeat (3) step();
        chk("sat_credits", credits_o, 16);
        chk("sticky_overflow", overflow_o, 1);

        send(16'hC3A5);
        step();
        calib_en = 1'b1;
        v_i      = 1'b1;
        data_i   = 16'h1234;
        repeat (10) step();
        chk("calib_active", calib_o, 1);
        chk("calib_credits", credits_o, 15);
        calib_en = 1'b0;
        v_i      = 1'b0;
        repeat (4) step();
        chk("calib_exit", calib_o, 0);

        send(16'h7E81);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_valid", valid_o, 0);
        chk("midrst_data", data_o, 0);
        chk("midrst_credits", credits_o, 16);
        chk("midrst_overflow", overflow_o, 0);
        chk("midrst_clk_o", clk_o, 0);
        q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) step();

        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
